// File: rtl/hc595_scan_driver.sv
// Multiplexed 7-segment scanner for a 74HC595 pair: segment byte then digit-select byte.
// New digit data is staged in a shadow set and becomes visible only at the start of a sweep.
module hc595_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 5,
  parameter int DWELL_CYC      = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    shcp,
  output logic                    stcp,
  output logic                    ser,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW         = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DWELL_LAST = (DWELL_CYC > 0) ? DWELL_CYC - 1 : 0;

  typedef enum logic [1:0] {DWELL, SHIFT, LATCH} state_t;

  state_t                  state;
  logic [CW-1:0]           div;
  logic [DW-1:0]           dwell_cnt;
  logic [3:0]              bit_idx;
  logic [IW-1:0]           digit_idx;
  logic [14:0]             sreg;
  logic [4*NUM_DIGITS-1:0] sh_digits, act_digits, src_digits;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp, src_dp;
  logic [NUM_DIGITS-1:0]   sh_blank, act_blank, src_blank;
  logic [3:0]              nibble;
  logic [7:0]              seg_byte, sel_byte;
  logic [15:0]             frame;
  logic                    tick, dwell_done, start, sweep_start;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick        = (div == CW'(CLK_DIV - 1));
  assign dwell_done  = (dwell_cnt == DW'(DWELL_LAST));
  assign start       = (state == DWELL) && dwell_done && en;
  assign sweep_start = start && (digit_idx == '0);

  // The first frame of a sweep is built from the shadow set, which becomes active on that same edge.
  always_comb begin
    src_digits = sweep_start ? sh_digits : act_digits;
    src_dp     = sweep_start ? sh_dp     : act_dp;
    src_blank  = sweep_start ? sh_blank  : act_blank;
    nibble     = src_digits[4*digit_idx +: 4];
    seg_byte   = src_blank[digit_idx] ? 8'h00 : {src_dp[digit_idx], hex7(nibble)};
    seg_byte   = seg_byte ^ {8{SEG_ACTIVE_LOW}};
    sel_byte   = (8'h01 << digit_idx) ^ {8{DIG_ACTIVE_LOW}};
    frame      = {seg_byte, sel_byte};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DWELL;
      div            <= '0;
      dwell_cnt      <= '0;
      bit_idx        <= '0;
      digit_idx      <= '0;
      sreg           <= '0;
      shcp           <= 1'b0;
      stcp           <= 1'b0;
      ser            <= 1'b0;
      frame_done     <= 1'b0;
      update_pending <= 1'b0;
      // NOTE: the digit sets are a handful of flops, not RAM; resetting them keeps the display dark until the first load.
      sh_digits      <= '0;
      act_digits     <= '0;
      sh_dp          <= '0;
      act_dp         <= '0;
      sh_blank       <= '1;
      act_blank      <= '1;
    end else begin
      frame_done <= 1'b0;

      // NOTE: non-blocking assignments let a coinciding load land in shadow while active takes the old shadow.
      if (sweep_start) begin
        act_digits <= sh_digits;
        act_dp     <= sh_dp;
        act_blank  <= sh_blank;
      end
      if (load) begin
        sh_digits      <= digit_data;
        sh_dp          <= dp_mask;
        sh_blank       <= blank_mask;
        update_pending <= 1'b1;
      end else if (sweep_start) begin
        update_pending <= 1'b0;
      end

      case (state)
        DWELL: begin
          div <= '0;
          if (!dwell_done) begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end else if (en) begin
            dwell_cnt <= '0;
            sreg      <= frame[14:0];
            ser       <= frame[15];
            shcp      <= 1'b0;
            bit_idx   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!tick) begin
            div <= div + 1'b1;
          end else begin
            div <= '0;
            if (!shcp) begin
              shcp <= 1'b1;
            end else begin
              shcp <= 1'b0;
              if (bit_idx == 4'd15) begin
                stcp  <= 1'b1;
                state <= LATCH;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                ser     <= sreg[14];
                sreg    <= {sreg[13:0], 1'b0};
              end
            end
          end
        end
        LATCH: begin
          if (!tick) begin
            div <= div + 1'b1;
          end else begin
            div        <= '0;
            stcp       <= 1'b0;
            frame_done <= 1'b1;
            digit_idx  <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            state      <= DWELL;
          end
        end
        default: state <= DWELL;
      endcase
    end
  end

endmodule

// File: doc/hc595_scan_driver.md
Name: hc595_scan_driver

Overview:
- Parametrised multiplexed 7-segment driver for a 74HC595 pair: one segment byte followed by one digit-select byte.
- Scans NUM_DIGITS hex digits continuously, each with its own decimal point and blank control.
- Digit updates are tear-free: new data takes effect only at the start of a sweep.
- Sits between the application (loads hex values) and the board pins SHCP/STCP/DS.

Parameters:
NUM_DIGITS, 8, digits scanned (1..8); select-byte bits >= NUM_DIGITS are always inactive
CLK_DIV, 5, clk cycles per shift-clock half period (>=1)
DWELL_CYC, 50000, idle clk cycles between one digit's latch and the next digit's shift start (0 allowed)
SEG_ACTIVE_LOW, 0, 1 inverts the whole segment byte (common anode)
DIG_ACTIVE_LOW, 1, 1 inverts the whole select byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable
load  in  1  one-cycle strobe that captures the three data inputs into shadow
digit_data  in  4*NUM_DIGITS  hex nibble per digit, digit d = [4d+3:4d]
dp_mask  in  NUM_DIGITS  decimal point per digit
blank_mask  in  NUM_DIGITS  1 = digit dark
shcp  out  1  shift clock to 595
stcp  out  1  latch clock to 595
ser  out  1  serial data to 595
frame_done  out  1  one-cycle pulse after each digit latch
update_pending  out  1  shadow loaded but not yet active

Behaviour:
- Single clock, rst asynchronous active-high. All outputs are registered.
- Reset values:
  - shcp=0, stcp=0, ser=0, frame_done=0, update_pending=0.
  - digit index=0, state=DWELL, dwell counter=0, divider=0.
  - Shadow and active sets: digits=0, dp=0, blank=all ones, so the display is dark until the first load.
- Reset asserted mid-frame aborts immediately to reset values. No partial latch is generated.
- Encoding:
  - Segment byte bit7=dp, bits6..0=gfedcba.
  - Hex table 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - Blanked digit: byte 00 (dp suppressed as well). Then SEG_ACTIVE_LOW inversion is applied.
  - Select byte: one-hot bit[digit index]. Then DIG_ACTIVE_LOW inversion is applied.
- Frame: 16 bits, shifted segment byte bit7 first, then select byte bit7 first.
- Divider: counts 0..CLK_DIV-1 only in SHIFT/LATCH and is held at 0 otherwise. tick = terminal count.
- States:
  - DWELL:
    - Counts DWELL_CYC cycles.
    - At the end, if en=1: build the frame from the active set, drive ser=frame[15] and shcp=0, bit index=0, enter SHIFT.
    - If en=0: hold in DWELL with the counter saturated. Resume on the first cycle en=1.
  - SHIFT:
    - On tick with shcp=0: shcp<=1 (595 samples ser on this edge).
    - On tick with shcp=1: shcp<=0.
      - If bit index=15, enter LATCH.
      - Otherwise increment the bit index and present the next bit on ser in the same edge.
    - Each bit lasts 2*CLK_DIV cycles. A frame shift lasts 32*CLK_DIV cycles.
  - LATCH:
    - stcp=1 for exactly CLK_DIV cycles.
    - On tick: stcp<=0, frame_done<=1 for one cycle, digit index advances (NUM_DIGITS-1 wraps to 0), enter DWELL.
  - en deasserted in SHIFT/LATCH: the current frame completes normally.
- Shadow/active:
  - load=1 copies all inputs to shadow and sets update_pending.
  - Shadow is copied to active on the DWELL->SHIFT edge when digit index=0. update_pending clears on that edge.
  - If load coincides with that edge, active takes the old shadow, the new data lands in shadow, and update_pending stays 1 until the next sweep.
  - Multiple loads before application: last load wins.
- ser is held stable from the falling shcp edge through the next rising edge. stcp rises only with shcp=0.

Test Plan:
- Reset, NUM_DIGITS=4, CLK_DIV=2, DWELL_CYC=4: after 4 cycles shift starts. First frame = segment 00, select FE (digit0 low). stcp high 2 cycles. frame_done at cycle 4+64+2. Digit period 70 cycles.
- load digit_data=16'h3210, dp_mask=4'b0010, blank=0 during digit 2: update_pending=1 until the next digit-0 start. Subsequent frames carry 3F/FE, 86/FD, 5B/FB, 4F/F7.
- load asserted on the exact digit-0 start cycle: that sweep shows the old data. The next sweep shows the new data. update_pending cleared at the second digit-0 start.
- en=0 mid-SHIFT of digit 1: frame 1 completes with stcp pulse and frame_done, then holds in DWELL with shcp=0. en=1 resumes at digit 2 after one cycle.
- SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0, digit value F with blank=1: segment byte FF, select byte one-hot high.
- rst pulsed during bit 9 of a frame: shcp/stcp/ser drop to 0 immediately. No stcp pulse occurs. Scan restarts at digit 0 after DWELL_CYC with the display blanked.
